// File: rtl/systolic_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_pkg
//   Shared definitions for the systolic job sequencer: the sequencer state
//   encoding and the default array/command geometry used when the top level
//   and its bus interface are instantiated without overrides.
//   No ports (package).
// -----------------------------------------------------------------------------
package systolic_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      OUTPUT = 3'd4
   } state_e;

   localparam int DEF_MAC_NUM    = 10;
   localparam int DEF_BW_ACT     = 8;
   localparam int DEF_BW_WET     = 8;
   localparam int DEF_BW_LEN     = 16;
   localparam int DEF_PE_LATENCY = 3;
   localparam int SHIFT_W        = 8;
   localparam int PERF_W         = 32;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl_if
//   Groups the four valid/ready channels of the job sequencer:
//     cmd_*  command (beat count + result shift), producer -> sequencer
//     act_*  activation vector, MAC_NUM signed lanes of BW_ACT bits
//     wet_*  weight vector, MAC_NUM signed lanes of BW_WET bits
//     res_*  quantised signed result, sequencer -> consumer
//   Lane i of a vector occupies bits [i*BW+:BW].
//   Modports: slave  = sequencer side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface systolic_seq_ctrl_if
   import systolic_ctrl_pkg::*;
#(
   parameter int MAC_NUM = DEF_MAC_NUM,
   parameter int BW_ACT  = DEF_BW_ACT,
   parameter int BW_WET  = DEF_BW_WET,
   parameter int BW_LEN  = DEF_BW_LEN
);

   logic                              cmd_valid;
   logic                              cmd_ready;
   logic        [BW_LEN-1:0]          cmd_len;
   logic        [SHIFT_W-1:0]         cmd_shift;

   logic                              act_valid;
   logic                              act_ready;
   logic        [MAC_NUM*BW_ACT-1:0]  act_data;

   logic                              wet_valid;
   logic                              wet_ready;
   logic        [MAC_NUM*BW_WET-1:0]  wet_data;

   logic                              res_valid;
   logic                              res_ready;
   logic signed [BW_ACT-1:0]          res_data;

   modport slave (
      input  cmd_valid, cmd_len, cmd_shift,
      output cmd_ready,
      input  act_valid, act_data,
      output act_ready,
      input  wet_valid, wet_data,
      output wet_ready,
      output res_valid, res_data,
      input  res_ready
   );

   modport master (
      output cmd_valid, cmd_len, cmd_shift,
      input  cmd_ready,
      output act_valid, act_data,
      input  act_ready,
      output wet_valid, wet_data,
      input  wet_ready,
      input  res_valid, res_data,
      output res_ready
   );

endinterface

// File: rtl/systolic_seq_ctrl_down_counter.sv
// -----------------------------------------------------------------------------
// sys_down_counter
//   Loadable down-counter with a zero flag. Load has priority over decrement;
//   a decrement at zero is ignored so the count never wraps.
//   Ports:
//     clk, reset_n   clock / async active-low reset (count -> 0)
//     load, load_val load a new count
//     dec            decrement by one
//     zero           count == 0
// -----------------------------------------------------------------------------
module sys_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//   Job sequencer for a 1xN systolic MAC array. Takes a dot-product command
//   (beat count, result shift), clears the array accumulators, streams paired
//   activation/weight vectors into the array, waits PE_LATENCY cycles for the
//   array pipeline to drain and hands the quantised result back over res_*.
//   FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> OUTPUT -> IDLE
//        (a zero-length command goes IDLE -> OUTPUT with a zero result).
//   Ports:
//     clk, reset_n         clock / async active-low reset (aborts any job)
//     bus (slave)          cmd/act/wet/res valid-ready channels
//     PE_mac_enable        array MAC enable, one cycle per accepted beat
//     PE_clear_acc         array accumulator clear, one cycle per job
//     PE_act_in/PE_wet_in  registered operand vectors to the array
//     PE_res_shift_num     result shift, driven during CLEAR..DRAIN
//     PE_result_out        quantised result from the array
//     busy                 state != IDLE
//   Optional build macro SYSTOLIC_SEQ_PERF_EN adds saturating counters:
//     perf_busy_cyc        cycles with busy = 1
//     perf_stall_cyc       STREAM cycles without a beat transfer
// -----------------------------------------------------------------------------
module systolic_seq_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int MAC_NUM    = DEF_MAC_NUM,
   parameter int BW_ACT     = DEF_BW_ACT,
   parameter int BW_WET     = DEF_BW_WET,
   parameter int BW_LEN     = DEF_BW_LEN,
   parameter int PE_LATENCY = DEF_PE_LATENCY
) (
   input  logic                             clk,
   input  logic                             reset_n,
   systolic_seq_ctrl_if.slave               bus,
   output logic                             PE_mac_enable,
   output logic                             PE_clear_acc,
   output logic        [MAC_NUM*BW_ACT-1:0] PE_act_in,
   output logic        [MAC_NUM*BW_WET-1:0] PE_wet_in,
   output logic        [SHIFT_W-1:0]        PE_res_shift_num,
   input  logic signed [BW_ACT-1:0]         PE_result_out,
   output logic                             busy
`ifdef SYSTOLIC_SEQ_PERF_EN
   ,
   output logic        [PERF_W-1:0]         perf_busy_cyc,
   output logic        [PERF_W-1:0]         perf_stall_cyc
`endif
);

   localparam int ACT_VEC_W = MAC_NUM * BW_ACT;
   localparam int WET_VEC_W = MAC_NUM * BW_WET;
   localparam int DRAIN_W   = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

   state_e                   state_q, state_d;
   logic                     ready_en_q, ready_en_d;
   logic [SHIFT_W-1:0]       shift_q, shift_d;
   logic                     pe_en_q, pe_en_d;
   logic [ACT_VEC_W-1:0]     pe_act_q, pe_act_d;
   logic [WET_VEC_W-1:0]     pe_wet_q, pe_wet_d;
   logic signed [BW_ACT-1:0] res_data_q, res_data_d;

   logic                     cmd_ready_c;
   logic                     clear_c;
   logic                     res_valid_c;
   logic                     beat_fire;
   logic                     beat_load;
   logic [BW_LEN-1:0]        beat_load_val;
   logic                     beat_zero;
   logic                     drain_load;
   logic                     drain_dec;
   logic                     drain_zero;

   // Beat counter holds (remaining beats - 1), so the zero flag marks the
   // final beat and a 2^BW_LEN-1 command still fits without wrapping.
   sys_down_counter #(.W(BW_LEN)) u_beat_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (beat_load),
      .load_val (beat_load_val),
      .dec      (beat_fire),
      .zero     (beat_zero)
   );

   // Drain counter is loaded on the last beat; its PE_LATENCY counted cycles
   // start with the final enable cycle, so terminal count is where the array
   // result is valid and gets captured.
   sys_down_counter #(.W(DRAIN_W)) u_drain_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (drain_load),
      .load_val (DRAIN_W'(PE_LATENCY - 1)),
      .dec      (drain_dec),
      .zero     (drain_zero)
   );

   always_comb begin
      state_d       = state_q;
      ready_en_d    = 1'b1;
      shift_d       = shift_q;
      pe_en_d       = 1'b0;
      pe_act_d      = pe_act_q;
      pe_wet_d      = pe_wet_q;
      res_data_d    = res_data_q;
      cmd_ready_c   = 1'b0;
      clear_c       = 1'b0;
      res_valid_c   = 1'b0;
      beat_fire     = 1'b0;
      beat_load     = 1'b0;
      beat_load_val = bus.cmd_len - BW_LEN'(1);
      drain_load    = 1'b0;
      drain_dec     = 1'b0;

      case (state_q)
         IDLE: begin
            // ready_en_q keeps cmd_ready low while reset is held and until
            // the first clock edge after release.
            cmd_ready_c = ready_en_q;
            if (bus.cmd_valid && ready_en_q) begin
               shift_d = bus.cmd_shift;
               if (bus.cmd_len != '0) begin
                  beat_load = 1'b1;
                  state_d   = CLEAR;
               end else begin
                  res_data_d = '0;
                  state_d    = OUTPUT;
               end
            end
         end

         CLEAR: begin
            clear_c = 1'b1;
            state_d = STREAM;
         end

         STREAM: begin
            // Both operand channels transfer together or not at all.
            beat_fire = bus.act_valid & bus.wet_valid;
            if (beat_fire) begin
               pe_en_d  = 1'b1;
               pe_act_d = bus.act_data;
               pe_wet_d = bus.wet_data;
               if (beat_zero) begin
                  drain_load = 1'b1;
                  state_d    = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (drain_zero) begin
               res_data_d = PE_result_out;
               state_d    = OUTPUT;
            end else begin
               drain_dec = 1'b1;
            end
         end

         OUTPUT: begin
            res_valid_c = 1'b1;
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ready_en_q <= 1'b0;
         shift_q    <= '0;
         pe_en_q    <= 1'b0;
         pe_act_q   <= '0;
         pe_wet_q   <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= ready_en_d;
         shift_q    <= shift_d;
         pe_en_q    <= pe_en_d;
         pe_act_q   <= pe_act_d;
         pe_wet_q   <= pe_wet_d;
         res_data_q <= res_data_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.act_ready = beat_fire;
   assign bus.wet_ready = beat_fire;
   assign bus.res_valid = res_valid_c;
   assign bus.res_data  = res_data_q;

   assign PE_mac_enable    = pe_en_q;
   assign PE_clear_acc     = clear_c;
   assign PE_act_in        = pe_act_q;
   assign PE_wet_in        = pe_wet_q;
   assign PE_res_shift_num = ((state_q == CLEAR) || (state_q == STREAM) ||
                              (state_q == DRAIN)) ? shift_q : '0;
   assign busy             = (state_q != IDLE);

`ifdef SYSTOLIC_SEQ_PERF_EN
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == '1) ? v : v + PERF_W'(1);
   endfunction

   logic [PERF_W-1:0] perf_busy_q, perf_busy_d;
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_busy_d  = perf_busy_q;
      perf_stall_d = perf_stall_q;
      if (state_q != IDLE) begin
         perf_busy_d = sat_inc(perf_busy_q);
      end
      if ((state_q == STREAM) && !beat_fire) begin
         perf_stall_d = sat_inc(perf_stall_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_busy_q  <= perf_busy_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_busy_cyc  = perf_busy_q;
   assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
